// File: rtl/led_breather.sv
// PWM LED breathing controller driven from a free-running clock counter.
// A selectable count bit provides the step tick; an FSM ramps brightness up, holds, ramps down and holds.
`timescale 1ns/1ps
module led_breather #(
  parameter int CNT_W      = 16,
  parameter int LVL_W      = 8,
  parameter int MAX_LEVEL  = 255,
  parameter int STEP       = 5,
  parameter int HOLD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] current_count,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       step_sel,
  output logic             pwm_out,
  output logic [LVL_W-1:0] level,
  output logic             ramping_up,
  output logic             cycle_done
);

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_SOLID   = 2'b01;
  localparam logic [1:0] M_BREATHE = 2'b10;

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  localparam logic [LVL_W:0]   STEP_X  = (LVL_W+1)'(STEP);
  localparam logic [LVL_W:0]   MAX_X   = (LVL_W+1)'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] STEP_SAT = (STEP >= MAX_LEVEL) ? LVL_W'(MAX_LEVEL) : LVL_W'(STEP);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_t;

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              pwm_q, pwm_d;
  logic              ramp_q;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sel_q;
  logic [3:0]        step_sel_q;
  logic [1:0]        mode_q;

  logic       sel_bit;
  logic       tick;
  logic [1:0] mode_eff;
  logic       mode_chg;

  // Upward step: reports whether the ramp has reached the peak, result clamped there.
  function automatic logic [LVL_W-1:0] sat_up(input logic [LVL_W-1:0] lvl, output logic at_top);
    logic [LVL_W:0] sum;
    sum    = {1'b0, lvl} + STEP_X;
    at_top = (sum >= MAX_X);
    return at_top ? MAX_LVL : sum[LVL_W-1:0];
  endfunction

  // Downward step: clamps at zero instead of wrapping.
  function automatic logic [LVL_W-1:0] sat_down(input logic [LVL_W-1:0] lvl, output logic at_bot);
    logic [LVL_W:0] diff;
    at_bot = ({1'b0, lvl} <= STEP_X);
    diff   = {1'b0, lvl} - STEP_X;
    return at_bot ? '0 : diff[LVL_W-1:0];
  endfunction

  assign sel_bit  = current_count[step_sel];
  // A step_sel change would compare bits from two different counter positions, so it never ticks.
  assign tick     = sel_bit & ~sel_q & (step_sel == step_sel_q);
  assign mode_eff = enable ? mode : M_OFF;
  assign mode_chg = (mode_eff != mode_q);

  always_comb begin
    logic       edge_hit;
    logic [LVL_W-1:0] nxt;
    state_d  = state_q;
    level_d  = level_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    edge_hit = 1'b0;
    nxt      = '0;

    if (mode_chg) begin
      state_d = IDLE;
      hold_d  = '0;
      level_d = (mode_eff == M_SOLID) ? MAX_LVL : '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mode_eff == M_BREATHE && tick) begin
            state_d = RAMP_UP;
            level_d = STEP_SAT;
          end else if (mode_eff == M_SOLID) begin
            level_d = MAX_LVL;
          end else begin
            level_d = '0;
          end
        end
        RAMP_UP: begin
          if (tick) begin
            nxt     = sat_up(level_q, edge_hit);
            level_d = nxt;
            if (edge_hit) state_d = (HOLD_TICKS == 0) ? RAMP_DOWN : HOLD_HIGH;
          end
        end
        HOLD_HIGH: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_d = RAMP_DOWN;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            nxt     = sat_down(level_q, edge_hit);
            level_d = nxt;
            if (edge_hit) begin
              if (HOLD_TICKS == 0) begin
                state_d = RAMP_UP;
                done_d  = 1'b1;
              end else begin
                state_d = HOLD_LOW;
              end
            end
          end
        end
        HOLD_LOW: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_d = RAMP_UP;
              level_d = STEP_SAT;
              hold_d  = '0;
              done_d  = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_d     = (mode_eff == M_SOLID) | (pwm_cnt_q < level_q);
  end

  // State, level and PWM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      level_q    <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      ramp_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= '0;
      sel_q      <= 1'b0;
      step_sel_q <= '0;
      mode_q     <= M_OFF;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
      ramp_q     <= (state_d == RAMP_UP);
      done_q     <= done_d;
      hold_q     <= hold_d;
      sel_q      <= sel_bit;
      step_sel_q <= step_sel;
      mode_q     <= mode_eff;
    end
  end

  assign pwm_out    = pwm_q;
  assign level      = level_q;
  assign ramping_up = ramp_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: reset, solid, a full breathe period, disable/re-enable,
// PWM duty measurement, step_sel switching and reset mid-ramp.
`timescale 1ns/1ps
module tb_led_breather;

  localparam int CNT_W = 16;
  localparam int LVL_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] current_count;
  logic             enable;
  logic [1:0]       mode;
  logic [3:0]       step_sel;
  logic             pwm_out;
  logic [LVL_W-1:0] level;
  logic             ramping_up;
  logic             cycle_done;

  int n_vec = 0;
  int n_err = 0;

  logic [CNT_W-1:0] cnt;
  bit               cnt_run;
  bit               tb_tick;
  bit               prev_bit;
  logic [3:0]       prev_sel;
  int               k;
  int               hi;

  always #5 clk = ~clk;

  led_breather #(
    .CNT_W(CNT_W), .LVL_W(LVL_W), .MAX_LEVEL(255), .STEP(5), .HOLD_TICKS(4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .current_count (current_count),
    .enable        (enable),
    .mode          (mode),
    .step_sel      (step_sel),
    .pwm_out       (pwm_out),
    .level         (level),
    .ramping_up    (ramping_up),
    .cycle_done    (cycle_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance past the edge, note whether that edge was a step tick, then drive the counter.
  task automatic step();
    logic b;
    b = current_count[step_sel];
    @(posedge clk);
    #1;
    if (rst) begin
      tb_tick  = 1'b0;
      prev_bit = 1'b0;
      prev_sel = '0;
    end else begin
      tb_tick  = b & ~prev_bit & (step_sel == prev_sel);
      prev_bit = b;
      prev_sel = step_sel;
    end
    if (cnt_run) begin
      cnt++;
      current_count = cnt;
    end
  endtask

  // Level after the k-th breathe tick: 51 up, 4 hold, 51 down, 4 hold, then the next ramp.
  function automatic int exp_level(input int t);
    if (t <= 51)  return 5 * t;
    if (t <= 55)  return 255;
    if (t <= 106) return 255 - 5 * (t - 55);
    if (t <= 109) return 0;
    return 5 * (t - 109);
  endfunction

  function automatic bit exp_ru(input int t);
    return (t >= 1 && t <= 50) || (t >= 110);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    enable        = 1'b1;
    mode          = 2'b01;
    step_sel      = 4'd5;
    current_count = 16'hFFFF;
    cnt           = '0;
    cnt_run       = 1'b0;
    prev_bit      = 1'b0;
    prev_sel      = '0;

    repeat (3) begin
      step();
      chk("rst_level", level, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_done", cycle_done, 0);
      chk("rst_ru", ramping_up, 0);
    end

    rst           = 1'b0;
    step_sel      = 4'd0;
    current_count = '0;
    step();
    chk("solid_level", level, 255);
    repeat (8) begin
      step();
      chk("solid_pwm", pwm_out, 1);
      chk("solid_level_hold", level, 255);
    end

    mode = 2'b10;
    step();
    chk("br_enter_level", level, 0);
    chk("br_enter_ru", ramping_up, 0);
    step();
    chk("br_pwm_off", pwm_out, 0);

    k       = 0;
    cnt     = '0;
    cnt_run = 1'b1;
    for (int c = 0; c < 400 && k < 129; c++) begin
      step();
      if (tb_tick) k++;
      chk("br_level", level, exp_level(k));
      chk("br_ru", ramping_up, exp_ru(k));
      chk("br_done", cycle_done, (tb_tick && k == 110));
    end

    cnt_run = 1'b0;
    chk("dis_pre_level", level, 100);
    enable = 1'b0;
    step();
    chk("dis_level", level, 0);
    chk("dis_ru", ramping_up, 0);
    step();
    chk("dis_pwm", pwm_out, 0);
    step();
    chk("dis_pwm_hold", pwm_out, 0);
    chk("dis_level_hold", level, 0);

    enable = 1'b1;
    step();
    chk("reen_enter_level", level, 0);
    k       = 0;
    cnt_run = 1'b1;
    for (int c = 0; c < 100 && k < 13; c++) begin
      step();
      if (tb_tick) k++;
      chk("reen_level", level, exp_level(k));
      chk("reen_ru", ramping_up, exp_ru(k));
    end
    cnt_run = 1'b0;

    step();
    step();
    chk("duty65_level", level, 65);
    hi = 0;
    repeat (256) begin
      step();
      hi += int'(pwm_out);
    end
    chk("duty65_high", hi, 65);
    chk("duty65_level_after", level, 65);

    enable = 1'b0;
    step();
    step();
    hi = 0;
    repeat (256) begin
      step();
      hi += int'(pwm_out);
    end
    chk("duty0_high", hi, 0);

    enable        = 1'b1;
    mode          = 2'b10;
    step_sel      = 4'd3;
    current_count = 16'd0;
    step();
    step();
    chk("ss_idle_level", level, 0);
    current_count = 16'd8;
    step();
    chk("ss_tick_bit3", level, 5);
    current_count = 16'd0;
    step();
    chk("ss_hold_a", level, 5);
    step_sel      = 4'd0;
    current_count = 16'd1;
    step();
    chk("ss_change_no_tick", level, 5);
    step();
    chk("ss_hold_b", level, 5);
    current_count = 16'd2;
    step();
    chk("ss_hold_c", level, 5);
    current_count = 16'd3;
    step();
    chk("ss_next_tick", level, 10);
    chk("ss_ru", ramping_up, 1);

    rst = 1'b1;
    step();
    chk("midrst_level", level, 0);
    chk("midrst_ru", ramping_up, 0);
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_done", cycle_done, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
